// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receiver: frame geometry, FSM states,
// and the odd-parity helper used when a frame completes.
package ps2_pkg;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;

    // Data edges in a frame: everything except start, parity and stop.
    localparam int DATA_EDGES = FRAME_BITS - 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // A frame is good when data plus parity hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data,
                                           input logic                 parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchronizer followed by a run-length level filter for one raw
// PS/2 line. With FILTER_LEN <= 1 the filter is bypassed and the output is
// the synchronized line itself.
module ps2_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);

    logic sync_1;
    logic sync_2;

    // Bring the asynchronous line into the clk domain; idles high like the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    generate
        if (FILTER_LEN <= 1) begin : g_bypass
            assign filt = sync_2;
        end else begin : g_filter
            localparam int CW = $clog2(FILTER_LEN);

            logic [CW-1:0] run_cnt;
            logic          level;

            // Flip the level only after FILTER_LEN consecutive opposite samples.
            always_ff @(posedge clk) begin
                if (rst) begin
                    level   <= 1'b1;
                    run_cnt <= '0;
                end else if (sync_2 == level) begin
                    run_cnt <= '0;
                end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
                    level   <= sync_2;
                    run_cnt <= '0;
                end else begin
                    run_cnt <= run_cnt + 1'b1;
                end
            end

            assign filt = level;
        end
    endgenerate

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: filters the bus, deframes 11-bit frames on
// falling clock edges, checks odd parity and the stop bit, and delivers bytes
// through a one-entry holding register with valid/ready handshake.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ         = 100_000_000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 err_parity,
    output logic                 err_frame,
    output logic                 err_overrun,
    output logic                 err_timeout
);

    // A non-positive timeout falls back to a 1 ms watchdog at the system clock.
    localparam int WD_LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : (CLK_HZ / 1000);
    localparam int WD_W     = $clog2(WD_LIMIT + 1);

    logic clk_filt;
    logic data_sync;
    logic clk_prev;
    logic fall_edge;

    state_t                state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic [WD_W-1:0]       wdog_q, wdog_d;

    logic push;
    logic bad_parity;
    logic bad_stop;
    logic timeout;

    ps2_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk (clk),
        .rst (rst),
        .raw (ps2_clk),
        .filt(clk_filt)
    );

    ps2_filter #(
        .FILTER_LEN(1)
    ) u_data_filter (
        .clk (clk),
        .rst (rst),
        .raw (ps2_data),
        .filt(data_sync)
    );

    // Remember the previous filtered clock level to spot 1->0 transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_prev <= 1'b1;
        end else begin
            clk_prev <= clk_filt;
        end
    end

    assign fall_edge = clk_prev & ~clk_filt;

    // Frame state, bit counter, shift register, parity bit and watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            wdog_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            wdog_q    <= wdog_d;
        end
    end

    // Deframing: advance one bit per falling edge, judge the frame at the stop bit.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        wdog_d     = wdog_q + 1'b1;
        push       = 1'b0;
        bad_parity = 1'b0;
        bad_stop   = 1'b0;
        timeout    = 1'b0;

        if (state_q == ST_IDLE || fall_edge) begin
            wdog_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (fall_edge && !data_sync) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (fall_edge) begin
                    shift_d   = {data_sync, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'(DATA_EDGES - 1)) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (fall_edge) begin
                    parity_d = data_sync;
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall_edge) begin
                    state_d = ST_IDLE;
                    if (!data_sync) begin
                        bad_stop = 1'b1;
                    end else if (odd_parity_ok(shift_q, parity_q)) begin
                        push = 1'b1;
                    end else begin
                        bad_parity = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_q != ST_IDLE && !fall_edge && wdog_q == WD_W'(WD_LIMIT - 1)) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            shift_d   = '0;
            wdog_d    = '0;
            timeout   = 1'b1;
        end
    end

    // Holding register with overrun detection, plus registered error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            err_parity  <= 1'b0;
            err_frame   <= 1'b0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            err_parity  <= bad_parity;
            err_frame   <= bad_stop;
            err_timeout <= timeout;
            err_overrun <= push && rx_valid && !rx_ready;
            if (push && (!rx_valid || rx_ready)) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
